// File: rtl/adc_conv_scheduler_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
package adc_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SEQ_W      = 8;
  localparam int PAD_W      = 8;
  localparam int TDATA_W    = 32;
  localparam int SAMPLE_LSB = 0;
  localparam int PAD_LSB    = 16;
  localparam int SEQ_LSB    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    START = 2'd2,
    CONV  = 2'd3
  } state_t;

  // Reload value for the period timer: max(period, min_period) - 1.
  function automatic logic [31:0] eff_period_m1(input logic [31:0] period,
                                                input logic [31:0] min_period);
    logic [31:0] eff;
    if (period < min_period) eff = min_period;
    else                     eff = period;
    return eff - 32'd1;
  endfunction

  // Output beat layout: {frame_seq, pad, sample}.
  function automatic logic [TDATA_W-1:0] pack_tdata(input logic [SEQ_W-1:0]    seq,
                                                    input logic [SAMPLE_W-1:0] sample);
    logic [TDATA_W-1:0] d;
    d = {TDATA_W{1'b0}};
    d[SEQ_LSB +: SEQ_W]       = seq;
    d[PAD_LSB +: PAD_W]       = {PAD_W{1'b0}};
    d[SAMPLE_LSB +: SAMPLE_W] = sample;
    return d;
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_period_timer.sv
// Load/reload down-counter. tick is high in the cycle the count sits at zero
// while running; the count then reloads from the last loaded value.
module adc_period_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         tick
);

  logic [W-1:0] count_r;
  logic [W-1:0] reload_r;

  assign tick = run && (count_r == {W{1'b0}});

  // Counter: explicit load wins, otherwise count down and reload at zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r  <= {W{1'b0}};
      reload_r <= {W{1'b0}};
    end else if (load) begin
      count_r  <= load_val;
      reload_r <= load_val;
    end else if (run) begin
      if (count_r == {W{1'b0}}) count_r <= reload_r;
      else                      count_r <= count_r - W'(1);
    end
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Paces capture-engine conversions at a fixed sample period, frames the
// results and presents them on an AXI-Stream master with tlast per frame.
module adc_conv_scheduler
  import adc_pkg::*;
#(
  parameter int MIN_PERIOD  = 64,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_enable,
  input  logic                cfg_continuous,
  input  logic [31:0]         cfg_period,
  input  logic [15:0]         cfg_frame_len,
  input  logic                arm,
  output logic                cap_start,
  input  logic                cap_valid,
  input  logic [SAMPLE_W-1:0] cap_data,
  input  logic                m_axis_tready,
  output logic                m_axis_tvalid,
  output logic [TDATA_W-1:0]  m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic                timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  state_t             state_r, state_nxt;
  logic               cap_start_r, cap_start_nxt;
  logic               busy_r, busy_nxt;
  logic               cont_r;
  logic [15:0]        len_m1_r;
  logic [15:0]        idx_r;
  logic [SEQ_W-1:0]   seq_r;
  logic               drop_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic               timeout_r;
  logic [CNT_W-1:0]   overrun_r;
  logic               tvalid_r;
  logic [TDATA_W-1:0] tdata_r;
  logic               tlast_r;

  logic tick_s, go_s, out_free_s, sample_s, is_last_s, abort_s, to_hit_s, ovr_ev_s;

  // Shared decode of the current cycle's events.
  assign go_s       = (state_r == IDLE) && cfg_enable && (cfg_continuous || arm);
  assign out_free_s = !tvalid_r || m_axis_tready;
  assign sample_s   = (state_r == CONV) && cap_valid;
  assign is_last_s  = (idx_r == len_m1_r);
  // A disable seen at any point of the conversion ends the frame early.
  assign abort_s    = drop_r || !cfg_enable;
  assign to_hit_s   = (state_r == CONV) && !cap_valid && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
  // Ticks during START/CONV, or with the holding register still full, are skipped.
  assign ovr_ev_s   = tick_s && (((state_r == WAIT) && cfg_enable && !out_free_s) ||
                                 (state_r == START) || (state_r == CONV));

  adc_period_timer #(.W(32)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (go_s),
    .load_val (eff_period_m1(cfg_period, 32'(MIN_PERIOD))),
    .run      (state_r != IDLE),
    .tick     (tick_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) state_nxt = WAIT;
        else      state_nxt = IDLE;
      end
      WAIT: begin
        if (!cfg_enable)              state_nxt = IDLE;
        else if (tick_s && out_free_s) state_nxt = START;
        else                          state_nxt = WAIT;
      end
      START: state_nxt = CONV;
      CONV: begin
        if (sample_s) begin
          if (abort_s)                 state_nxt = IDLE;
          else if (is_last_s && !cont_r) state_nxt = IDLE;
          else                         state_nxt = WAIT;
        end else if (to_hit_s) begin
          if (abort_s) state_nxt = IDLE;
          else         state_nxt = WAIT;
        end else begin
          state_nxt = CONV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes computed from the next state so they can be registered.
  always_comb begin
    cap_start_nxt = (state_nxt == START);
    busy_nxt      = (state_nxt != IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cap_start_r <= cap_start_nxt;
      busy_r      <= busy_nxt;
    end
  end

  // Configuration captured only when a run starts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cont_r   <= 1'b0;
      len_m1_r <= 16'd0;
    end else if (go_s) begin
      cont_r   <= cfg_continuous;
      len_m1_r <= (cfg_frame_len == 16'd0) ? 16'd0 : (cfg_frame_len - 16'd1);
    end
  end

  // Sample index within the frame and frame sequence number.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_r <= 16'd0;
      seq_r <= {SEQ_W{1'b0}};
    end else if (sample_s) begin
      if (is_last_s) begin
        idx_r <= 16'd0;
        seq_r <= seq_r + SEQ_W'(1);
      end else if (abort_s) begin
        idx_r <= 16'd0;
      end else begin
        idx_r <= idx_r + 16'd1;
      end
    end else if ((state_r == WAIT) && !cfg_enable) begin
      idx_r <= 16'd0;
    end else if (to_hit_s && abort_s) begin
      idx_r <= 16'd0;
    end
  end

  // Remember a disable that happens while a conversion is in flight.
  always_ff @(posedge clk) begin
    if (!resetn)                                        drop_r <= 1'b0;
    else if ((state_r == IDLE) || (state_r == WAIT))    drop_r <= 1'b0;
    else if (!cfg_enable)                               drop_r <= 1'b1;
  end

  // Conversion timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt_r  <= {TO_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (state_r == START)                  to_cnt_r <= {TO_W{1'b0}};
      else if ((state_r == CONV) && !cap_valid) to_cnt_r <= to_cnt_r + TO_W'(1);
      if (to_hit_s) timeout_r <= 1'b1;
    end
  end

  // Saturating count of skipped ticks.
  always_ff @(posedge clk) begin
    if (!resetn) overrun_r <= {CNT_W{1'b0}};
    else if (ovr_ev_s && (overrun_r != {CNT_W{1'b1}})) overrun_r <= overrun_r + CNT_W'(1);
  end

  // AXI-Stream holding register: load on capture, clear on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tvalid_r <= 1'b0;
      tdata_r  <= {TDATA_W{1'b0}};
      tlast_r  <= 1'b0;
    end else if (sample_s) begin
      tvalid_r <= 1'b1;
      tdata_r  <= pack_tdata(seq_r, cap_data);
      tlast_r  <= is_last_s;
    end else if (tvalid_r && m_axis_tready) begin
      tvalid_r <= 1'b0;
    end
  end

  assign cap_start     = cap_start_r;
  assign busy          = busy_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign overrun_cnt   = overrun_r;
  assign timeout_err   = timeout_r;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler with a modelled capture engine.
module tb_adc_conv_scheduler;

  localparam int TIMEOUT_CYC = 4096;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_continuous = 1'b0;
  logic [31:0] cfg_period = 32'd100;
  logic [15:0] cfg_frame_len = 16'd4;
  logic        arm = 1'b0;
  logic        cap_start;
  logic        cap_valid = 1'b0;
  logic [15:0] cap_data = 16'd0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] overrun_cnt;
  logic        timeout_err;

  always #5 clk = ~clk;

  adc_conv_scheduler #(.MIN_PERIOD(64), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_period(cfg_period), .cfg_frame_len(cfg_frame_len), .arm(arm),
    .cap_start(cap_start), .cap_valid(cap_valid), .cap_data(cap_data),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  int cyc = 0;
  int beats = 0;
  int starts = 0;
  int last_start = -1;
  int exp_spacing = 0;
  int rsp_lat = 20;
  bit rsp_en = 1'b1;
  int rst_gen = 0;
  int m_idx = 0;
  int m_seq = 0;
  int m_len = 4;
  bit m_drop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Capture-engine model: answers cap_start after rsp_lat cycles and predicts the beat.
  initial begin : responder
    int gen;
    logic [15:0] d;
    logic lst;
    forever begin
      @(negedge clk);
      if (resetn && cap_start) begin
        gen = rst_gen;
        if (last_start >= 0 && exp_spacing != 0)
          chk_eq("start_spacing", 64'(cyc - last_start), 64'(exp_spacing));
        last_start = cyc;
        starts++;
        if (rsp_en) begin
          repeat (rsp_lat - 1) @(negedge clk);
          if (gen == rst_gen) begin
            d = 16'($urandom);
            lst = (m_idx == m_len - 1);
            exp_q.push_back({lst, 8'(m_seq), 8'h00, d});
            if (lst) begin
              m_idx = 0;
              m_seq = (m_seq + 1) % 256;
            end else if (m_drop) begin
              m_idx = 0;
            end else begin
              m_idx++;
            end
            m_drop = 1'b0;
            cap_data = d;
            cap_valid = 1'b1;
            @(negedge clk);
            cap_valid = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: every accepted beat is popped from the scoreboard.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && m_axis_tvalid && m_axis_tready) begin
        beats++;
        chk_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_eq("tdata", 64'(m_axis_tdata), 64'(e[31:0]));
          chk_eq("tlast", 64'(m_axis_tlast), 64'(e[32]));
        end
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    cfg_enable = 1'b0;
    arm = 1'b0;
    rst_gen++;
    exp_q.delete();
    m_idx = 0; m_seq = 0; m_drop = 1'b0;
    last_start = -1; exp_spacing = 0;
    @(negedge clk);
    chk_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk_eq("rst_cap_start", 64'(cap_start), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_overrun", 64'(overrun_cnt), 64'd0);
    chk_eq("rst_timeout", 64'(timeout_err), 64'd0);
    resetn = 1'b1;
    beats = 0; starts = 0;
    @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int lim);
    int k = 0;
    while (beats < n && k < lim) begin @(negedge clk); k++; end
    if (beats < n) chk_eq("wait_beats", 64'(beats), 64'(n));
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (starts < n && k < lim) begin @(negedge clk); k++; end
    if (starts < n) chk_eq("wait_starts", 64'(starts), 64'(n));
  endtask

  task automatic run_cfg(input bit cont, input int period, input int len);
    cfg_continuous = cont;
    cfg_period = 32'(period);
    cfg_frame_len = 16'(len);
    m_len = (len == 0) ? 1 : len;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int s;
    int changes;
    int n0;
    logic [31:0] d0;

    do_reset();

    // 1: continuous framing, period 100, len 4, three frames
    m_axis_tready = 1'b1; rsp_en = 1'b1; rsp_lat = 20;
    run_cfg(1'b1, 100, 4);
    exp_spacing = 100;
    cfg_enable = 1'b1;
    wait_beats(12, 1400);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t1_busy_off", 64'(busy), 64'd0);
    chk_eq("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_eq("t1_overrun", 64'(overrun_cnt), 64'd0);

    // 2: single-shot, len 3, second arm while busy is ignored
    do_reset();
    run_cfg(1'b0, 100, 3);
    exp_spacing = 100;
    cfg_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("t2_idle_no_arm", 64'(busy), 64'd0);
    arm = 1'b1; @(negedge clk); arm = 1'b0;
    repeat (50) @(negedge clk);
    chk_eq("t2_busy", 64'(busy), 64'd1);
    arm = 1'b1; @(negedge clk); arm = 1'b0;
    wait_beats(3, 500);
    repeat (3) @(negedge clk);
    chk_eq("t2_busy_after", 64'(busy), 64'd0);
    repeat (300) @(negedge clk);
    chk_eq("t2_beats", 64'(beats), 64'd3);
    chk_eq("t2_starts", 64'(starts), 64'd3);
    chk_eq("t2_still_idle", 64'(busy), 64'd0);

    // 3: backpressure, held sample and overrun accounting
    do_reset();
    @(posedge clk); #1 m_axis_tready = 1'b0;
    run_cfg(1'b1, 100, 4);
    cfg_enable = 1'b1;
    n0 = 0;
    while (!m_axis_tvalid && n0 < 300) begin @(negedge clk); n0++; end
    chk_eq("t3_first_valid", 64'(m_axis_tvalid), 64'd1);
    d0 = m_axis_tdata;
    changes = 0;
    for (int i = 0; i < 350; i++) begin
      @(negedge clk);
      if (!m_axis_tvalid || m_axis_tdata != d0) changes++;
    end
    chk_eq("t3_held_stable", 64'(changes), 64'd0);
    chk_eq("t3_overrun", 64'(overrun_cnt), 64'd3);
    chk_eq("t3_starts", 64'(starts), 64'd1);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    wait_beats(3, 400);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t3_overrun_after", 64'(overrun_cnt), 64'd3);

    // 4: period below minimum is clamped to 64
    do_reset();
    run_cfg(1'b1, 10, 4);
    exp_spacing = 64;
    cfg_enable = 1'b1;
    wait_starts(4, 400);
    m_drop = 1'b1;
    cfg_enable = 1'b0;
    repeat (40) @(negedge clk);
    chk_eq("t4_busy_off", 64'(busy), 64'd0);
    chk_eq("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: capture never answers -> timeout, then next tick restarts
    do_reset();
    rsp_en = 1'b0;
    run_cfg(1'b1, 100, 4);
    cfg_enable = 1'b1;
    wait_starts(1, 200);
    s = last_start;
    while (cyc < s + TIMEOUT_CYC - 2) @(negedge clk);
    chk_eq("t5_no_timeout_yet", 64'(timeout_err), 64'd0);
    while (cyc < s + TIMEOUT_CYC + 2) @(negedge clk);
    chk_eq("t5_timeout", 64'(timeout_err), 64'd1);
    chk_eq("t5_overrun", 64'(overrun_cnt), 64'd40);
    n0 = starts;
    wait_starts(n0 + 1, 120);
    chk_eq("t5_no_output", 64'(beats), 64'd0);
    chk_eq("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    rsp_en = 1'b1;

    // 6: disable mid-frame during CONV, then re-enable
    do_reset();
    run_cfg(1'b1, 100, 8);
    exp_spacing = 100;
    cfg_enable = 1'b1;
    wait_beats(2, 400);
    wait_starts(3, 200);
    repeat (5) @(negedge clk);
    m_drop = 1'b1;
    cfg_enable = 1'b0;
    wait_beats(3, 60);
    repeat (3) @(negedge clk);
    chk_eq("t6_idle", 64'(busy), 64'd0);
    last_start = -1;
    cfg_enable = 1'b1;
    wait_beats(12, 1200);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // 7: reset with a pending, un-accepted beat
    do_reset();
    @(posedge clk); #1 m_axis_tready = 1'b0;
    run_cfg(1'b1, 100, 4);
    cfg_enable = 1'b1;
    n0 = 0;
    while (!m_axis_tvalid && n0 < 300) begin @(negedge clk); n0++; end
    chk_eq("t7_pending", 64'(m_axis_tvalid), 64'd1);
    do_reset();
    m_axis_tready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
